// File: rtl/memory_access_sequencer_pkg.sv
// Shared types for the memory access sequencer: memory port modes and FSM states.
package memory_access_sequencer_pkg;

  typedef enum logic [1:0] {
    MM_NOP           = 2'd0,
    MM_LOAD          = 2'd1,
    MM_STORE_PRELOAD = 2'd2,
    MM_STORE         = 2'd3
  } MemoryMode_t;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_PRELOAD = 3'd2,
    S_STORE   = 3'd3,
    S_FAULT   = 3'd4
  } MemSeqState_t;

endpackage

// File: rtl/memory_access_sequencer_if.sv
// Request/memory-port bundle between core control, the sequencer and the memory controller.
// master = the sequencer, slave = core control / memory controller side.
interface memory_access_sequencer_if;
  import memory_access_sequencer_pkg::*;

  logic        start;
  logic        isLoad;
  logic        isStore;
  logic [2:0]  funct3In;
  logic        memoryUnalignedAccess;
  logic        memoryBadFunct3;
  logic        clearFault;
  MemoryMode_t memoryMode;
  logic [2:0]  funct3;
  logic        busy;
  logic        rdWriteEnable;
  logic        done;
  logic        fault;

  modport master (
    input  start, isLoad, isStore, funct3In, memoryUnalignedAccess, memoryBadFunct3, clearFault,
    output memoryMode, funct3, busy, rdWriteEnable, done, fault
  );

  modport slave (
    output start, isLoad, isStore, funct3In, memoryUnalignedAccess, memoryBadFunct3, clearFault,
    input  memoryMode, funct3, busy, rdWriteEnable, done, fault
  );

endinterface

// File: rtl/memory_access_sequencer_perf_counters.sv
// Three wrapping event counters (load done, store done, fault entry) for the sequencer.
module mem_seq_perf_counters #(
  parameter int unsigned COUNTER_WIDTH = 32
) (
  input  logic                     clock_i,
  input  logic                     reset_i,
  input  logic                     load_done_i,
  input  logic                     store_done_i,
  input  logic                     fault_entry_i,
  output logic [COUNTER_WIDTH-1:0] loadCount_o,
  output logic [COUNTER_WIDTH-1:0] storeCount_o,
  output logic [COUNTER_WIDTH-1:0] faultCount_o
);

  logic [COUNTER_WIDTH-1:0] load_cnt_q, store_cnt_q, fault_cnt_q;

  // Count event pulses; counters wrap naturally and are cleared only by reset.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      load_cnt_q  <= '0;
      store_cnt_q <= '0;
      fault_cnt_q <= '0;
    end else begin
      if (load_done_i)   load_cnt_q  <= load_cnt_q  + COUNTER_WIDTH'(1);
      if (store_done_i)  store_cnt_q <= store_cnt_q + COUNTER_WIDTH'(1);
      if (fault_entry_i) fault_cnt_q <= fault_cnt_q + COUNTER_WIDTH'(1);
    end
  end

  assign loadCount_o  = load_cnt_q;
  assign storeCount_o = store_cnt_q;
  assign faultCount_o = fault_cnt_q;

endmodule

// File: rtl/memory_access_sequencer.sv
// Sequences the memory controller data port for one load/store at a time,
// inserting the read-modify-write preload cycle and trapping controller errors.
// Optional feature macro: MEM_SEQ_PERF_COUNTERS_EN adds load/store/fault counters.
//
// state   | meaning
// IDLE    | waiting for start, memoryMode=NOP
// LOAD    | memoryMode=LOAD for LOAD_LATENCY+1 cycles, rd write on last
// PRELOAD | memoryMode=STORE_PRELOAD, error flags checked before any write
// STORE   | memoryMode=STORE, write commits, done
// FAULT   | sticky error, waits for clearFault
module memory_access_sequencer
  import memory_access_sequencer_pkg::*;
#(
  parameter int unsigned LOAD_LATENCY = 1
`ifdef MEM_SEQ_PERF_COUNTERS_EN
  , parameter int unsigned COUNTER_WIDTH = 32
`endif
) (
  input  logic                     clock_i,
  input  logic                     reset_i,
  memory_access_sequencer_if.master bus
`ifdef MEM_SEQ_PERF_COUNTERS_EN
  , output logic [COUNTER_WIDTH-1:0] loadCount_o
  , output logic [COUNTER_WIDTH-1:0] storeCount_o
  , output logic [COUNTER_WIDTH-1:0] faultCount_o
`endif
);

  localparam logic [2:0] LAT_RELOAD = 3'(LOAD_LATENCY);

  MemSeqState_t state_q, state_d;
  logic [2:0]   funct3_q, funct3_d;
  logic [2:0]   lat_cnt_q, lat_cnt_d;
  MemoryMode_t  mode;
  logic         rd_we;
  logic         done_p;
  logic         mem_err;

  assign mem_err = bus.memoryUnalignedAccess | bus.memoryBadFunct3;

  // State, latched funct3 and load latency down-counter.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      funct3_q  <= 3'b000;
      lat_cnt_q <= 3'd0;
    end else begin
      state_q   <= state_d;
      funct3_q  <= funct3_d;
      lat_cnt_q <= lat_cnt_d;
    end
  end

  // Next-state and memory-port outputs; outputs depend only on state so the
  // controller's flags (combinational from memoryMode) cannot form a loop.
  always_comb begin
    state_d   = state_q;
    funct3_d  = funct3_q;
    lat_cnt_d = lat_cnt_q;
    mode      = MM_NOP;
    rd_we     = 1'b0;
    done_p    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          funct3_d = bus.funct3In;
          if (bus.isLoad && !bus.isStore) begin
            state_d   = S_LOAD;
            lat_cnt_d = LAT_RELOAD;
          end else if (bus.isStore && !bus.isLoad) begin
            state_d = S_PRELOAD;
          end else begin
            state_d = S_FAULT;
          end
        end
      end
      S_LOAD: begin
        mode = MM_LOAD;
        if (mem_err) begin
          state_d = S_FAULT;
        end else if (lat_cnt_q == 3'd0) begin
          rd_we   = 1'b1;
          done_p  = 1'b1;
          state_d = S_IDLE;
        end else begin
          lat_cnt_d = lat_cnt_q - 3'd1;
        end
      end
      S_PRELOAD: begin
        mode    = MM_STORE_PRELOAD;
        state_d = mem_err ? S_FAULT : S_STORE;
      end
      S_STORE: begin
        mode    = MM_STORE;
        done_p  = 1'b1;
        state_d = S_IDLE;
      end
      S_FAULT: begin
        if (bus.clearFault) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.memoryMode    = mode;
  assign bus.funct3        = funct3_q;
  assign bus.busy          = (state_q != S_IDLE);
  assign bus.rdWriteEnable = rd_we;
  assign bus.done          = done_p;
  assign bus.fault         = (state_q == S_FAULT);

`ifdef MEM_SEQ_PERF_COUNTERS_EN
  logic load_done, store_done, fault_entry;

  assign load_done   = done_p && (state_q == S_LOAD);
  assign store_done  = done_p && (state_q == S_STORE);
  assign fault_entry = (state_d == S_FAULT) && (state_q != S_FAULT);

  mem_seq_perf_counters #(
    .COUNTER_WIDTH(COUNTER_WIDTH)
  ) u_perf (
    .clock_i      (clock_i),
    .reset_i      (reset_i),
    .load_done_i  (load_done),
    .store_done_i (store_done),
    .fault_entry_i(fault_entry),
    .loadCount_o  (loadCount_o),
    .storeCount_o (storeCount_o),
    .faultCount_o (faultCount_o)
  );
`endif

endmodule
